// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the inverse-direction datapath.
// Byte k of a block sits at [127-8k -: 8]; column c holds bytes 4c..4c+3 (row r = byte 4c+r).
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic {IDLE, RUN} inv_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] x09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] x0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] x0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] x0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = x0e(a0) ^ x0b(a1) ^ x0d(a2) ^ x09(a3);
            o[119-32*c -: 8] = x09(a0) ^ x0e(a1) ^ x0b(a2) ^ x0d(a3);
            o[111-32*c -: 8] = x0d(a0) ^ x09(a1) ^ x0e(a2) ^ x0b(a3);
            o[103-32*c -: 8] = x0b(a0) ^ x0d(a1) ^ x09(a2) ^ x0e(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// Reverse AES-128 key schedule step: given round key i, produce round key i-1.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_i,
    input  logic [3:0]   rnd_idx_i,
    output logic [127:0] rk_prev_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w1p, w2p, w3p, rot, sub;

    assign {w0, w1, w2, w3} = rk_i;
    assign w3p = w3 ^ w2;
    assign w2p = w2 ^ w1;
    assign w1p = w1 ^ w0;
    assign rot = {w3p[23:0], w3p[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.in_i(rot[8*b +: 8]), .dec_i(1'b0), .out_o(sub[8*b +: 8]));
    end

    assign rk_prev_o = {w0 ^ sub ^ {rcon(rnd_idx_i), 24'h0}, w1p, w2p, w3p};
endmodule

// File: rtl/aes_sbox.sv
// Forward/inverse AES S-box; dec_i selects the inverse. SBOX_GF builds the
// field-inversion form, otherwise a pair of constant tables is used.
module aes_sbox (
    input  logic [7:0] in_i,
    input  logic       dec_i,
    output logic [7:0] out_o
);
`ifdef SBOX_GF
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
        end
        return p;
    endfunction

    // a^254 == a^-1 (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] x);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] x);
        return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    endfunction

    assign out_o = dec_i ? gf_inv(inv_aff(in_i)) : aff(gf_inv(in_i));
`else
    localparam logic [0:255][7:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [0:255][7:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    assign out_o = dec_i ? INV[in_i] : FWD[in_i];
`endif
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock, round keys derived
// backwards from the round-10 key supplied at load.
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic [127:0] data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] data_o
);
    inv_state_e   fsm_q, fsm_d;
    logic [127:0] state_q, state_d, rk_q, rk_d, data_q, data_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic [127:0] shifted, subbed, rk_n, rnd_out;

    assign shifted = inv_shift_rows(state_q);

    for (genvar b = 0; b < 16; b++) begin : g_sbox
        aes_sbox u_sbox (.in_i(shifted[127-8*b -: 8]), .dec_i(1'b1), .out_o(subbed[127-8*b -: 8]));
    end

    // rk_q holds the key of round rnd+1; step back one round each cycle.
    aes_inv_key_step u_key_step (
        .rk_i     (rk_q),
        .rnd_idx_i(rnd_q + 4'd1),
        .rk_prev_o(rk_n)
    );

    assign rnd_out = subbed ^ rk_n;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (load_i) begin
                    state_d = data_i ^ key_i;
                    rk_d    = key_i;
                    rnd_d   = 4'(AES_NR - 1);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                rk_d    = rk_n;
                state_d = (rnd_q == 4'd0) ? rnd_out : inv_mix_columns(rnd_out);
                if (rnd_q == 4'd0) begin
                    data_d = rnd_out;
                    done_d = 1'b1;
                    fsm_d  = IDLE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (fsm_q == RUN);
    assign done_o = done_q;
    assign data_o = data_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS vectors, multi-cycle corner cases and random
// blocks encrypted by a byte-array AES-128 model whose S-box is derived from GF math.
module tb_aes_inv_cipher_iter;
    logic         clk = 1'b0;
    logic         reset, load_i, busy_o, done_o;
    logic [127:0] key_i, data_i, data_o;

    always #5 clk = ~clk;

    aes_inv_cipher_iter dut (
        .clk(clk), .reset(reset), .load_i(load_i), .key_i(key_i), .data_i(data_i),
        .busy_o(busy_o), .done_o(done_o), .data_o(data_o)
    );

    int checks = 0, failures = 0;
    logic [7:0] sb [256];

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] C1_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_K  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] x, int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int k = 1; k < 256; k++)
            if (gm(a, 8'(k)) == 8'h01) inv = 8'(k);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] rkey(logic [127:0] key, int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] encrypt(logic [127:0] pt, logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] blk;
        blk = pt ^ rkey(key, 0);
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sb[blk[127-8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end else begin
                    for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*c+rr];
                end
            end
            for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = s[k];
            blk ^= rkey(key, r);
        end
        return blk;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called on a falling edge; returns on the falling edge of the done cycle (or timeout).
    task automatic run_op(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] prev,
                          output logic [127:0] pt, output int lat, output int busy_err, output int stab_err);
        load_i = 1'b1; key_i = key; data_i = ct;
        busy_err = 0; stab_err = 0;
        @(negedge clk);
        load_i = 1'b0; key_i = rnd128(); data_i = rnd128();
        lat = 1;
        while (!done_o && lat < 40) begin
            if (!busy_o) busy_err++;
            if (data_o !== prev) stab_err++;
            @(negedge clk);
            lat++;
        end
        pt = data_o;
    endtask

    vec_t         vt [4];
    logic [127:0] pt, prev, got, k0, p0;
    int           lat, be, se, ndone, dlat, lat_err, busy_tot, stab_tot;

    initial begin
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        reset = 1'b1; load_i = 1'b0; key_i = '0; data_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {127'b0, busy_o}, 128'd0);
        chk("reset_done", {127'b0, done_o}, 128'd0);
        chk("reset_data", data_o, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        vt[0] = '{"c1", C1_K, C1_C, C1_P};
        vt[1] = '{"appb", B_K, B_C, B_P};
        for (int i = 2; i < 4; i++) begin
            k0 = rnd128(); p0 = rnd128();
            vt[i] = '{"tbl_rand", rkey(k0, 10), encrypt(p0, k0), p0};
        end
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            run_op(vt[i].key, vt[i].ct, prev, pt, lat, be, se);
            chk({vt[i].name, "_pt"}, pt, vt[i].pt);
            chk({vt[i].name, "_latency"}, 128'(lat), 128'd11);
            chk({vt[i].name, "_busy_run"}, 128'(be), 128'd0);
            chk({vt[i].name, "_hold"}, 128'(se), 128'd0);
            chk({vt[i].name, "_busy_done"}, {127'b0, busy_o}, 128'd0);
            prev = vt[i].pt;
            @(negedge clk);
            chk({vt[i].name, "_done_pulse"}, {127'b0, done_o}, 128'd0);
        end

        // Round-9 key after the first RUN cycle.
        load_i = 1'b1; key_i = B_K; data_i = B_C;
        @(negedge clk); load_i = 1'b0;
        @(negedge clk);
        chk("appb_rk9", dut.rk_q, 128'hac7766f319fadc2128d12941575c006e);
        for (int c = 0; c < 40 && !done_o; c++) @(negedge clk);
        chk("appb_probe_pt", data_o, B_P);
        @(negedge clk);

        // Back-to-back: App. B loaded in C.1's done cycle.
        run_op(C1_K, C1_C, B_P, pt, lat, be, se);
        chk("b2b_c1_pt", pt, C1_P);
        chk("b2b_c1_lat", 128'(lat), 128'd11);
        chk("b2b_c1_busy_done", {127'b0, busy_o}, 128'd0);
        run_op(B_K, B_C, C1_P, pt, lat, be, se);
        chk("b2b_b_pt", pt, B_P);
        chk("b2b_b_lat", 128'(lat), 128'd11);
        chk("b2b_b_busy_run", 128'(be), 128'd0);
        chk("b2b_b_busy_done", {127'b0, busy_o}, 128'd0);
        @(negedge clk);

        // Load while busy is ignored.
        load_i = 1'b1; key_i = C1_K; data_i = C1_C;
        @(negedge clk);
        ndone = 0; dlat = 0; got = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done_o) begin ndone++; dlat = cyc; got = data_o; end
            load_i = (cyc == 4);
            key_i = rnd128(); data_i = rnd128();
            @(negedge clk);
        end
        load_i = 1'b0;
        chk("lwb_done_count", 128'(ndone), 128'd1);
        chk("lwb_done_lat", 128'(dlat), 128'd11);
        chk("lwb_pt", got, C1_P);

        // Reset in the middle of a run.
        load_i = 1'b1; key_i = C1_K; data_i = C1_C;
        @(negedge clk);
        load_i = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {127'b0, busy_o}, 128'd0);
        chk("rst_done", {127'b0, done_o}, 128'd0);
        chk("rst_data", data_o, 128'd0);
        ndone = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (done_o) ndone++;
            @(negedge clk);
        end
        chk("rst_no_done", 128'(ndone), 128'd0);
        run_op(B_K, B_C, 128'd0, pt, lat, be, se);
        chk("rst_then_b_pt", pt, B_P);
        chk("rst_then_b_lat", 128'(lat), 128'd11);
        prev = B_P;

        // Random blocks encrypted by the model, decrypted by the DUT.
        lat_err = 0; busy_tot = 0; stab_tot = 0;
        for (int n = 0; n < 1000; n++) begin
            k0 = rnd128(); p0 = rnd128();
            run_op(rkey(k0, 10), encrypt(p0, k0), prev, pt, lat, be, se);
            chk("rand_pt", pt, p0);
            if (lat != 11) lat_err++;
            busy_tot += be; stab_tot += se;
            prev = p0;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        chk("rand_latency_errs", 128'(lat_err), 128'd0);
        chk("rand_busy_errs", 128'(busy_tot), 128'd0);
        chk("rand_hold_errs", 128'(stab_tot), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
